agendador_ciclo: RTL and testbench
==================================

AGENDADOR_CICLO -- requirements
Module: agendador_ciclo

Interface
REQ-001 Parameter PERIODO, default 16: number of clock edges spent in ESPERA before each cycle; legal range 2..255.
REQ-002 Parameter T_MAX_MOTOR, default 10: number of consecutive MOTOR=1 cycles in ATIVO that trips the watchdog; legal range 1..255.
REQ-003 clock  in  1  single system clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 habilita  in  1  scheduler enable; level-sensitive.
REQ-006 ack  in  1  operator acknowledge; releases BLOQUEADO.
REQ-007 MOTOR, EV, ALARME  in  1 each  status outputs fed back from the main irrigation state machine (mef_principal); treated as synchronous to clock.
REQ-008 start  out  1  drives the start input of the main state machine.
REQ-009 alarme_lat  out  1  latched alarm flag.
REQ-010 falha_timeout  out  1  latched watchdog fault flag.
REQ-011 ciclos  out  4  count of completed cycles, modulo 16.
REQ-012 estado  out  2  current state: OCIOSO=00, ESPERA=01, ATIVO=10, BLOQUEADO=11.

Function
REQ-013 All outputs SHALL be registered or decoded only from registered state; there SHALL be no combinational path from any input to any output.
REQ-014 start SHALL be 1 exactly when estado=ATIVO.
REQ-015 OCIOSO: if habilita=1, go to ESPERA and clear the wait counter; otherwise hold.
REQ-016 ESPERA: the wait counter SHALL increment once per edge; at the edge where counter=PERIODO-1, go to ATIVO; ATIVO is therefore entered PERIODO edges after ESPERA is entered.
REQ-017 ESPERA: habilita=0 SHALL go to OCIOSO, with priority over the counter expiry.
REQ-018 ATIVO: internal flag visto SHALL be set when MOTOR=1 or EV=1; visto SHALL be cleared on entry to ATIVO.
REQ-019 ATIVO: the watchdog counter SHALL increment while MOTOR=1 and clear when MOTOR=0; it SHALL also clear on entry to ATIVO.
REQ-020 ATIVO transitions, in priority order:
  (a) ALARME=1 -> BLOQUEADO, set alarme_lat;
  (b) watchdog counter=T_MAX_MOTOR-1 with MOTOR=1 -> BLOQUEADO, set falha_timeout;
  (c) habilita=0 -> OCIOSO;
  (d) visto=1 and MOTOR=0 and EV=0 -> ESPERA, ciclos+1, wait counter cleared.
REQ-021 If (a) and (b) are true on the same edge, both alarme_lat and falha_timeout SHALL be set.
REQ-022 ciclos SHALL wrap from 15 to 0, and SHALL be retained through OCIOSO and BLOQUEADO.
REQ-023 BLOQUEADO: start=0; habilita SHALL be ignored; ack=1 with ALARME=0 SHALL go to OCIOSO and clear alarme_lat and falha_timeout on the same edge; ack=1 while ALARME=1 SHALL be ignored.
REQ-024 alarme_lat and falha_timeout SHALL change only as defined in REQ-020, REQ-021 and REQ-023 (and on reset).

Reset
REQ-025 While reset=1, regardless of clock: estado=OCIOSO, start=0, alarme_lat=0, falha_timeout=0, ciclos=0, and all internal counters and visto=0.
REQ-026 Reset asserted mid-operation SHALL abort immediately to the values in REQ-025; after reset deassertion, operation SHALL resume from OCIOSO at the first rising edge.

Configuration
REQ-027 Macro AGENDADOR_WATCHDOG_EN defined: the watchdog counter and transition REQ-020(b) SHALL be implemented.
REQ-028 AGENDADOR_WATCHDOG_EN undefined: the watchdog counter SHALL be absent, falha_timeout SHALL be constant 0, and REQ-020(b) and REQ-021 SHALL not apply; all other behaviour is unchanged.

Verification (PERIODO=4, T_MAX_MOTOR=5, watchdog enabled unless noted)
REQ-029 reset pulse, then habilita=1 -> estado 00->01; start rises exactly 4 edges after ESPERA entry; ciclos=0.
REQ-030 In ATIVO: MOTOR=1 for 3 cycles, then MOTOR=EV=0 -> back to ESPERA, ciclos=1, start=0; repeat 16 full cycles -> ciclos wraps to 0.
REQ-031 In ATIVO: MOTOR held at 1 -> BLOQUEADO on the 5th consecutive MOTOR=1 edge, falha_timeout=1, start=0; ack=1 -> OCIOSO, flags cleared.
REQ-032 In ATIVO: ALARME and MOTOR timeout on the same edge -> both flags=1; ack=1 with ALARME=1 -> stays BLOQUEADO; drop ALARME, then ack=1 -> OCIOSO.
REQ-033 habilita=0 in ESPERA and in ATIVO -> OCIOSO next edge; reset asserted between edges in ATIVO -> start=0 immediately.
REQ-034 AGENDADOR_WATCHDOG_EN undefined: MOTOR held at 1 for 300 cycles -> remains ATIVO, falha_timeout=0.

Source files
------------

// File: rtl/agendador_ciclo.sv
// Cycle scheduler for the main irrigation FSM: waits PERIODO edges, runs one cycle, counts completed cycles.
// Optional motor watchdog is compiled in when AGENDADOR_WATCHDOG_EN is defined.
module agendador_ciclo #(
    parameter int PERIODO     = 16,
    parameter int T_MAX_MOTOR = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       ack,
    input  logic       MOTOR,
    input  logic       EV,
    input  logic       ALARME,
    output logic       start,
    output logic       alarme_lat,
    output logic       falha_timeout,
    output logic [3:0] ciclos,
    output logic [1:0] estado
);

    // One width serves both the wait counter and the watchdog counter.
    localparam int CNT_MAX = (PERIODO > T_MAX_MOTOR) ? PERIODO : T_MAX_MOTOR;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] ESPERA_FIM = CNT_W'(PERIODO - 1);

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        ESPERA    = 2'b01,
        ATIVO     = 2'b10,
        BLOQUEADO = 2'b11
    } estado_t;

    estado_t          est, prox;
    logic [CNT_W-1:0] cnt_espera;
    logic             visto;
    logic             alarme_r;
    logic             trip;

`ifdef AGENDADOR_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_FIM = CNT_W'(T_MAX_MOTOR - 1);
    logic [CNT_W-1:0] cnt_wd;
    logic             falha_r;

    assign trip = MOTOR && (cnt_wd == WD_FIM);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_wd  <= '0;
            falha_r <= 1'b0;
        end else begin
            cnt_wd <= (est == ATIVO && MOTOR) ? cnt_wd + 1'b1 : '0;
            if (est == ATIVO && trip)
                falha_r <= 1'b1;
            else if (est == BLOQUEADO && ack && !ALARME)
                falha_r <= 1'b0;
        end
    end

    assign falha_timeout = falha_r;
`else
    assign trip          = 1'b0;
    assign falha_timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) est <= OCIOSO;
        else       est <= prox;
    end

    always_comb begin
        prox = est;
        case (est)
            OCIOSO:    if (habilita) prox = ESPERA;
            ESPERA: begin
                if (!habilita)                      prox = OCIOSO;
                else if (cnt_espera == ESPERA_FIM)  prox = ATIVO;
            end
            ATIVO: begin
                if (ALARME || trip)                 prox = BLOQUEADO;
                else if (!habilita)                 prox = OCIOSO;
                else if (visto && !MOTOR && !EV)    prox = ESPERA;
            end
            BLOQUEADO: if (ack && !ALARME) prox = OCIOSO;
            default:   prox = OCIOSO;
        endcase
    end

    always_comb begin
        start  = (est == ATIVO);
        estado = est;
    end

    // Counters outside their own state are held at zero, which gives the clear-on-entry behaviour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_espera <= '0;
            visto      <= 1'b0;
            ciclos     <= 4'd0;
            alarme_r   <= 1'b0;
        end else begin
            cnt_espera <= (est == ESPERA) ? cnt_espera + 1'b1 : '0;
            visto      <= (est == ATIVO) ? (visto | MOTOR | EV) : 1'b0;
            if (est == ATIVO && prox == ESPERA)
                ciclos <= ciclos + 4'd1;
            if (est == ATIVO && ALARME)
                alarme_r <= 1'b1;
            else if (est == BLOQUEADO && ack && !ALARME)
                alarme_r <= 1'b0;
        end
    end

    assign alarme_lat = alarme_r;

endmodule

// File: tb/tb_agendador_ciclo.sv
// Directed bench for agendador_ciclo with PERIODO=4, T_MAX_MOTOR=5.
// Watchdog expectations follow AGENDADOR_WATCHDOG_EN.
module tb_agendador_ciclo;

    logic       clock = 1'b0;
    logic       reset, habilita, ack, MOTOR, EV, ALARME;
    logic       start, alarme_lat, falha_timeout;
    logic [3:0] ciclos;
    logic [1:0] estado;

    int checks   = 0;
    int failures = 0;

`ifdef AGENDADOR_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    agendador_ciclo #(.PERIODO(4), .T_MAX_MOTOR(5)) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .ack(ack),
        .MOTOR(MOTOR), .EV(EV), .ALARME(ALARME), .start(start),
        .alarme_lat(alarme_lat), .falha_timeout(falha_timeout),
        .ciclos(ciclos), .estado(estado)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_cycle;
        repeat (4) tick;
        MOTOR = 1'b1;
        repeat (3) tick;
        MOTOR = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        habilita = 1'b1;
        repeat (2) tick;
        checks++; if (estado !== 2'b00) begin failures++; $display("FAIL reset_estado got=%0d exp=0", estado); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b exp=0", start); end
        checks++; if (alarme_lat !== 1'b0 || falha_timeout !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", alarme_lat, falha_timeout); end
        checks++; if (ciclos !== 4'd0) begin failures++; $display("FAIL reset_ciclos got=%0d exp=0", ciclos); end
        habilita = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_inicio;
        habilita = 1'b1;
        tick;
        checks++; if (estado !== 2'b01) begin failures++; $display("FAIL inicio_espera got=%0d exp=1", estado); end
        repeat (3) tick;
        checks++; if (start !== 1'b0 || estado !== 2'b01) begin failures++; $display("FAIL inicio_3 got=%0b/%0d exp=0/1", start, estado); end
        tick;
        checks++; if (start !== 1'b1 || estado !== 2'b10) begin failures++; $display("FAIL inicio_4 got=%0b/%0d exp=1/2", start, estado); end
        checks++; if (ciclos !== 4'd0) begin failures++; $display("FAIL inicio_ciclos got=%0d exp=0", ciclos); end
    endtask

    task automatic test_ciclos;
        MOTOR = 1'b1;
        repeat (3) tick;
        checks++; if (estado !== 2'b10) begin failures++; $display("FAIL ciclo_ativo got=%0d exp=2", estado); end
        MOTOR = 1'b0;
        tick;
        checks++; if (estado !== 2'b01 || start !== 1'b0) begin failures++; $display("FAIL ciclo_fim got=%0d/%0b exp=1/0", estado, start); end
        checks++; if (ciclos !== 4'd1) begin failures++; $display("FAIL ciclo_conta got=%0d exp=1", ciclos); end
        for (int i = 2; i <= 16; i++) begin
            do_cycle;
            if (i == 15) begin
                checks++; if (ciclos !== 4'd15) begin failures++; $display("FAIL ciclo_15 got=%0d exp=15", ciclos); end
            end
        end
        checks++; if (ciclos !== 4'd0 || estado !== 2'b01) begin failures++; $display("FAIL ciclo_wrap got=%0d/%0d exp=0/1", ciclos, estado); end
    endtask

    task automatic test_watchdog;
        do_cycle;
        repeat (4) tick;
        checks++; if (estado !== 2'b10) begin failures++; $display("FAIL wd_ativo got=%0d exp=2", estado); end
        MOTOR = 1'b1;
        if (WD) begin
            repeat (4) tick;
            checks++; if (estado !== 2'b10) begin failures++; $display("FAIL wd_4 got=%0d exp=2", estado); end
            tick;
            checks++; if (estado !== 2'b11 || start !== 1'b0) begin failures++; $display("FAIL wd_trip got=%0d/%0b exp=3/0", estado, start); end
            checks++; if (falha_timeout !== 1'b1 || alarme_lat !== 1'b0) begin failures++; $display("FAIL wd_flags got=%0b%0b exp=01", alarme_lat, falha_timeout); end
            habilita = 1'b0;
            MOTOR    = 1'b0;
            tick;
            checks++; if (estado !== 2'b11) begin failures++; $display("FAIL wd_hold got=%0d exp=3", estado); end
            ack = 1'b1;
            tick;
            checks++; if (estado !== 2'b00 || falha_timeout !== 1'b0) begin failures++; $display("FAIL wd_ack got=%0d/%0b exp=0/0", estado, falha_timeout); end
            ack = 1'b0;
        end else begin
            repeat (300) tick;
            checks++; if (estado !== 2'b10 || start !== 1'b1) begin failures++; $display("FAIL nowd_ativo got=%0d/%0b exp=2/1", estado, start); end
            checks++; if (falha_timeout !== 1'b0) begin failures++; $display("FAIL nowd_falha got=%0b exp=0", falha_timeout); end
            MOTOR    = 1'b0;
            habilita = 1'b0;
            tick;
            checks++; if (estado !== 2'b00) begin failures++; $display("FAIL nowd_sai got=%0d exp=0", estado); end
        end
        checks++; if (ciclos !== 4'd1) begin failures++; $display("FAIL wd_ciclos got=%0d exp=1", ciclos); end
    endtask

    task automatic test_alarme;
        habilita = 1'b1;
        tick;
        repeat (4) tick;
        MOTOR = 1'b1;
        repeat (4) tick;
        checks++; if (estado !== 2'b10) begin failures++; $display("FAIL al_ativo got=%0d exp=2", estado); end
        ALARME = 1'b1;
        tick;
        checks++; if (estado !== 2'b11) begin failures++; $display("FAIL al_bloq got=%0d exp=3", estado); end
        checks++; if (alarme_lat !== 1'b1 || falha_timeout !== WD) begin failures++; $display("FAIL al_flags got=%0b%0b exp=1%0b", alarme_lat, falha_timeout, WD); end
        ack = 1'b1;
        tick;
        checks++; if (estado !== 2'b11 || alarme_lat !== 1'b1) begin failures++; $display("FAIL al_ack_ign got=%0d/%0b exp=3/1", estado, alarme_lat); end
        ALARME = 1'b0;
        ack    = 1'b0;
        MOTOR  = 1'b0;
        tick;
        checks++; if (estado !== 2'b11) begin failures++; $display("FAIL al_hold got=%0d exp=3", estado); end
        ack = 1'b1;
        tick;
        checks++; if (estado !== 2'b00 || alarme_lat !== 1'b0 || falha_timeout !== 1'b0) begin failures++; $display("FAIL al_lib got=%0d/%0b%0b exp=0/00", estado, alarme_lat, falha_timeout); end
        ack      = 1'b0;
        habilita = 1'b0;
        tick;
    endtask

    task automatic test_habilita;
        habilita = 1'b1;
        tick;
        tick;
        habilita = 1'b0;
        tick;
        checks++; if (estado !== 2'b00) begin failures++; $display("FAIL hab_espera got=%0d exp=0", estado); end
        habilita = 1'b1;
        tick;
        repeat (3) tick;
        checks++; if (estado !== 2'b01) begin failures++; $display("FAIL hab_pre got=%0d exp=1", estado); end
        habilita = 1'b0;
        tick;
        checks++; if (estado !== 2'b00) begin failures++; $display("FAIL hab_prio got=%0d exp=0", estado); end
        habilita = 1'b1;
        tick;
        repeat (4) tick;
        checks++; if (estado !== 2'b10) begin failures++; $display("FAIL hab_ativo got=%0d exp=2", estado); end
        habilita = 1'b0;
        tick;
        checks++; if (estado !== 2'b00 || start !== 1'b0) begin failures++; $display("FAIL hab_sai got=%0d/%0b exp=0/0", estado, start); end
    endtask

    task automatic test_reset_async;
        habilita = 1'b1;
        tick;
        repeat (4) tick;
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL rst_pre got=%0b exp=1", start); end
        #2 reset = 1'b1;
        #1;
        checks++; if (start !== 1'b0 || estado !== 2'b00) begin failures++; $display("FAIL rst_async got=%0b/%0d exp=0/0", start, estado); end
        checks++; if (ciclos !== 4'd0) begin failures++; $display("FAIL rst_ciclos got=%0d exp=0", ciclos); end
        tick;
        reset = 1'b0;
        tick;
        checks++; if (estado !== 2'b01) begin failures++; $display("FAIL rst_resume got=%0d exp=1", estado); end
    endtask

    initial begin
        reset = 1'b1; habilita = 1'b0; ack = 1'b0;
        MOTOR = 1'b0; EV = 1'b0; ALARME = 1'b0;
        test_reset;
        test_inicio;
        test_ciclos;
        test_watchdog;
        test_alarme;
        test_habilita;
        test_reset_async;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
